// File: rtl/neuron_scheduler.sv
// -----------------------------------------------------------------------------
// neuron_scheduler
//
// Time-multiplexed leaky integrate-and-fire scheduler. One step pulse walks
// every neuron once: it reads the neuron's membrane value, compares it with
// the threshold, integrates the input current with a 1/8 leak and writes the
// neuron back. Spiking neurons are queued as events in a small FIFO. When the
// FIFO is full, the walk stalls until the consumer frees an entry.
//
// Optional feature: define SPIKE_COUNT_EN to add a saturating 16-bit counter
// of FIFO pushes on output spike_count.
//
// Parameters
//   N_NEURONS   number of neurons (2..16)
//   FIFO_DEPTH  spike-event FIFO entries (power of two, >= 2)
//   THR_RESET   threshold value loaded at reset
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   step              pulse that starts one timestep (ignored while busy)
//   cur_addr/cur_data neuron being updated / its input current, same cycle
//   cfg_we/cfg_thr    threshold write, accepted only in IDLE
//   ev_valid/ev_ready/ev_id  spike-event stream (valid/ready handshake)
//   busy              high while a timestep is in progress
//   done              one-cycle pulse when a timestep completes
//   spike_count       (SPIKE_COUNT_EN only) saturating count of pushes
// -----------------------------------------------------------------------------
module neuron_scheduler #(
  parameter int N_NEURONS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int THR_RESET  = 200
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         step,
  output logic [$clog2(N_NEURONS)-1:0] cur_addr,
  input  logic [7:0]                   cur_data,
  input  logic                         cfg_we,
  input  logic [7:0]                   cfg_thr,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [$clog2(N_NEURONS)-1:0] ev_id,
  output logic                         busy,
  output logic                         done
`ifdef SPIKE_COUNT_EN
  ,
  output logic [15:0]                  spike_count
`endif
);

  localparam int AW = $clog2(N_NEURONS);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [7:0]    THR_INIT = 8'(THR_RESET);

  typedef enum logic [1:0] {IDLE, UPDATE, STALL} state_t;

  // Integrate, leak by 1/8 of the 9-bit sum, clamp to 8 bits.
  function automatic logic [7:0] leak_sat(input logic [7:0] m, input logic [7:0] c);
    logic [8:0] sum;
    logic [8:0] leak;
    sum  = {1'b0, m} + {1'b0, c};
    leak = sum - (sum >> 3);
    leak_sat = (leak > 9'd255) ? 8'hFF : leak[7:0];
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [7:0]        thr_q, thr_d;
  logic [7:0]        mem_q [N_NEURONS];
  logic [7:0]        mem_d [N_NEURONS];
  logic              done_q, done_d;

  logic [AW-1:0]     fifo_q [FIFO_DEPTH];
  logic [AW-1:0]     fifo_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [7:0]        cur_mem;
  logic [7:0]        nxt;
  logic              spk;
  logic              full;
  logic              push;
  logic              pop;

  assign cur_mem  = mem_q[idx_q];
  assign spk      = (cur_mem >= thr_q);
  assign nxt      = leak_sat(cur_mem, cur_data);
  // Fullness comes from the registered count, so a pop in the same cycle
  // never makes room for a push.
  assign full     = (count_q == DEPTH_C);
  assign ev_valid = (count_q != '0);
  assign pop      = ev_valid & ev_ready;

  assign busy     = (state_q != IDLE);
  assign cur_addr = busy ? idx_q : '0;
  assign ev_id    = ev_valid ? fifo_q[rd_ptr_q] : '0;
  assign done     = done_q;

  // Scheduler next-state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    thr_d   = thr_q;
    mem_d   = mem_q;
    done_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_we) thr_d = cfg_thr;
        if (step) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      UPDATE: begin
        if (spk && full) begin
          // Hold mem and idx; the same neuron is re-evaluated after the stall.
          state_d = STALL;
        end else begin
          push         = spk;
          mem_d[idx_q] = spk ? 8'd0 : nxt;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      STALL: begin
        if (!full) state_d = UPDATE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Event FIFO next-state
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = idx_q;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      thr_q    <= THR_INIT;
      mem_q    <= '{default: '0};
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      thr_q    <= thr_d;
      mem_q    <= mem_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO payload carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

`ifdef SPIKE_COUNT_EN
  logic [15:0] spike_count_q, spike_count_d;

  always_comb begin
    spike_count_d = spike_count_q;
    if (push && (spike_count_q != 16'hFFFF)) spike_count_d = spike_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spike_count_q <= '0;
    else        spike_count_q <= spike_count_d;
  end

  assign spike_count = spike_count_q;
`endif

endmodule
